// File: rtl/jtag_pkg.sv
// Shared definitions for the CGRA serial configuration link (jtag_tx sender, jtag2 loader).
// Holds the transmitter state encoding and the default image geometry.
package jtag_pkg;

    localparam int WORD_W_DEF = 32;
    localparam int DEPTH_DEF  = 4096;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } jtag_state_e;

endpackage

// File: rtl/jtag_tx.sv
// Serial configuration bitstream transmitter: fetches image words from a synchronous
// memory and streams them LSB-first, one bit per clock, gap-free across word boundaries.
module jtag_tx
    import jtag_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int LEN_W  = $clog2(DEPTH) + 1,
    parameter int ADDR_W = $clog2(DEPTH / WORD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rd_data,
    output logic              data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              done,
    output jtag_state_e       dbg_state
);

    localparam int WIDX_W = $clog2(WORD_W);
    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WORD_W - 1);
    localparam logic [WIDX_W-1:0] WIDX_ONE  = WIDX_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
    localparam logic [LEN_W:0]    W_EXT     = (LEN_W + 1)'(WORD_W);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    // Handshake: mem_rd_en is a one-cycle request; mem_rd_data is consumed exactly one
    // cycle later (rd_pend_q marks that cycle). No backpressure on either side.
    jtag_state_e       state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] shadow_q, shadow_d;
    logic [LEN_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_en_q, rd_en_d;
    logic              rd_pend_q, rd_pend_d;
    logic              data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [WORD_W-1:0] next_word;
    logic [LEN_W-1:0]  next_bit;
    logic              more_words;

    // The word arriving this cycle bypasses the shadow, which matters when WORD_W is 2.
    assign next_word  = rd_pend_q ? mem_rd_data : shadow_q;
    assign next_bit   = (state_q == ST_SHIFT) ? (bit_cnt_q + LEN_ONE) : '0;
    assign more_words = (({1'b0, next_bit} + W_EXT) < {1'b0, len_q});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            shadow_q     <= '0;
            bit_cnt_q    <= '0;
            widx_q       <= '0;
            len_q        <= '0;
            addr_q       <= '0;
            rd_en_q      <= 1'b0;
            rd_pend_q    <= 1'b0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            shadow_q     <= shadow_d;
            bit_cnt_q    <= bit_cnt_d;
            widx_q       <= widx_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            rd_en_q      <= rd_en_d;
            rd_pend_q    <= rd_pend_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        shadow_d     = rd_pend_q ? mem_rd_data : shadow_q;
        bit_cnt_d    = bit_cnt_q;
        widx_d       = widx_q;
        len_d        = len_q;
        addr_d       = addr_q;
        rd_en_d      = 1'b0;
        rd_pend_d    = rd_en_q;
        data_out_d   = 1'b0;
        data_valid_d = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d  = len;
                    busy_d = 1'b1;
                    addr_d = '0;
                    if (len == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        rd_en_d = 1'b1;
                    end
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                state_d      = ST_SHIFT;
                shreg_d      = next_word;
                data_out_d   = next_word[0];
                data_valid_d = 1'b1;
                bit_cnt_d    = '0;
                widx_d       = '0;
                if (more_words) begin
                    rd_en_d = 1'b1;
                    addr_d  = addr_q + ADDR_ONE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == len_q - LEN_ONE) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    bit_cnt_d    = next_bit;
                    data_valid_d = 1'b1;
                    if (widx_q == WIDX_LAST) begin
                        widx_d  = '0;
                        shreg_d = next_word;
                        if (more_words) begin
                            rd_en_d = 1'b1;
                            addr_d  = addr_q + ADDR_ONE;
                        end
                    end else begin
                        widx_d  = widx_q + WIDX_ONE;
                        shreg_d = shreg_q >> 1;
                    end
                    data_out_d = shreg_d[0];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort outranks everything once a transfer has been accepted.
        if (abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            rd_en_d      = 1'b0;
            rd_pend_d    = 1'b0;
            data_out_d   = 1'b0;
            data_valid_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b0;
        end
    end

    assign mem_rd_en  = rd_en_q;
    assign mem_addr   = addr_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_jtag_tx.sv
// Bench for jtag_tx: per-cycle comparison against a cycle-index model of the transfer,
// plus directed literal checks and randomized transfers with aborts and stray starts.
module tb_jtag_tx;
  import jtag_pkg::*;

  localparam int W      = 32;
  localparam int DEPTH  = 128;
  localparam int LEN_W  = $clog2(DEPTH) + 1;
  localparam int ADDR_W = $clog2(DEPTH / W);
  localparam int NW     = DEPTH / W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [W-1:0]      mem_rd_data = '0;
  logic              data_out, data_valid, busy, done;
  jtag_state_e       dbg_state;

  jtag_tx #(.WORD_W(W), .DEPTH(DEPTH), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .data_out(data_out), .data_valid(data_valid), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // memory: data valid only the cycle after a read, garbage otherwise
  logic [W-1:0] mem [NW];
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_addr] : W'($urandom);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int last_cycle(input int l);
    return (l == 0) ? 1 : l + 3;
  endfunction

  function automatic logic img_bit(input int i);
    logic [W-1:0] w;
    w = mem[i / W];
    return w[i % W];
  endfunction

  // model: which cycle of which transfer we are in
  int m_active = 0;
  int m_t = 0;
  int m_len = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) m_active = 0;
    else if (m_active == 0) begin
      if (start) begin
        m_active = 1; m_t = 1; m_len = int'(len);
      end
    end else if (abort) m_active = 0;
    else begin
      m_t++;
      if (m_t > last_cycle(m_len)) m_active = 0;
    end
  end

  // scoreboard: expected serial bits, observed bits / reads / done cycle
  logic exp_q[$];
  logic rx_q[$];
  int   rd_addr_q[$];
  int   done_at = -1;

  logic e_done, e_valid, e_rd;
  int   e_addr;
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_busy", busy, 0); chk("rst_valid", data_valid, 0); chk("rst_done", done, 0);
      chk("rst_rd_en", mem_rd_en, 0); chk("rst_dout", data_out, 0); chk("rst_addr", mem_addr, 0);
    end else begin
      e_done  = (m_active != 0) && (m_t == last_cycle(m_len));
      e_valid = (m_active != 0) && (m_len > 0) && (m_t >= 3) && (m_t <= m_len + 2);
      e_rd    = (m_active != 0) && (m_len > 0) &&
                ((m_t == 1) || ((m_t >= 3) && ((m_t - 3) % W == 0) && ((m_t - 3) + W < m_len)));
      e_addr  = (m_t == 1) ? 0 : (m_t - 3) / W + 1;
      chk("busy", busy, m_active);
      chk("done", done, e_done);
      chk("data_valid", data_valid, e_valid);
      chk("mem_rd_en", mem_rd_en, e_rd);
      if (e_valid) chk("data_out", data_out, img_bit(m_t - 3));
      if (e_rd) chk("mem_addr", mem_addr, e_addr);
      if (data_valid) rx_q.push_back(data_out);
      if (mem_rd_en) rd_addr_q.push_back(int'(mem_addr));
      if (done) done_at = m_t;
    end
  end

  task automatic clear_obs();
    rx_q.delete(); rd_addr_q.delete(); exp_q.delete(); done_at = -1;
  endtask

  task automatic check_rx(input string name);
    chk({name, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) chk({name, "_bit"}, rx_q[i], exp_q[i]);
  endtask

  // driver: start at edge 0; loop body runs at the negedge inside cycle t
  task automatic do_xfer(input int l, input int abort_at, input bit stray_start, input bit abort_w_start);
    int n;
    clear_obs();
    @(negedge clk);
    len = LEN_W'(l); start = 1'b1; abort = abort_w_start;
    for (int t = 1; t <= last_cycle(l) + 2; t++) begin
      @(negedge clk);
      start = stray_start && (t == 5);
      abort = (t == abort_at);
      len   = LEN_W'($urandom_range(0, DEPTH));
    end
    start = 1'b0; abort = 1'b0;
    n = l;
    if (abort_at >= 1 && abort_at <= last_cycle(l)) n = (abort_at - 2 < l) ? ((abort_at > 2) ? abort_at - 2 : 0) : l;
    for (int i = 0; i < n; i++) exp_q.push_back(img_bit(i));
    chk("idle_after", busy, 0);
  endtask

  task automatic fill_mem();
    for (int i = 0; i < NW; i++) mem[i] = W'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a5_rx;
    fill_mem();
    // reset held: outputs stay 0 while start toggles
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); start = ~start; len = LEN_W'(8);
    end
    start = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_state", dbg_state, ST_IDLE);

    // 0xA5, 8 bits
    mem[0] = 32'h0000_00A5;
    do_xfer(8, -1, 0, 0);
    a5_rx = '0;
    for (int i = 0; i < 8 && i < rx_q.size(); i++) a5_rx[i] = rx_q[i];
    chk("a5_bits", a5_rx, 8'b1010_0101);
    chk("a5_count", rx_q.size(), 8);
    chk("a5_done_cycle", done_at, 11);
    chk("a5_reads", rd_addr_q.size(), 1);
    if (rd_addr_q.size() > 0) chk("a5_read_addr", rd_addr_q[0], 0);

    // 70 bits across three words
    mem[0] = 32'hDEAD_BEEF; mem[1] = 32'h0F1E_2D3C; mem[2] = 32'h8000_0001;
    do_xfer(70, -1, 0, 0);
    check_rx("len70");
    chk("len70_reads", rd_addr_q.size(), 3);
    for (int i = 0; i < rd_addr_q.size() && i < 3; i++) chk("len70_addr", rd_addr_q[i], i);
    chk("len70_done_cycle", done_at, 73);

    // zero length
    do_xfer(0, -1, 0, 0);
    chk("len0_done_cycle", done_at, 1);
    chk("len0_reads", rd_addr_q.size(), 0);
    chk("len0_bits", rx_q.size(), 0);

    // start while busy is ignored
    fill_mem();
    do_xfer(40, -1, 1, 0);
    check_rx("stray_start");
    chk("stray_start_count", rx_q.size(), 40);

    // abort during the 10th valid bit, then a short transfer
    do_xfer(40, 12, 0, 0);
    chk("abort_count", rx_q.size(), 10);
    chk("abort_no_done", done_at, -1);
    mem[0] = 32'h0000_000A;
    do_xfer(4, -1, 0, 0);
    check_rx("after_abort");
    chk("after_abort_reads", rd_addr_q.size(), 1);
    if (rd_addr_q.size() > 0) chk("after_abort_addr", rd_addr_q[0], 0);

    // full depth: counter must not wrap
    fill_mem();
    do_xfer(DEPTH, -1, 0, 0);
    check_rx("full_depth");
    chk("full_depth_done_cycle", done_at, DEPTH + 3);

    // asynchronous reset mid-transfer
    @(negedge clk); len = LEN_W'(60); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_busy", busy, 0); chk("async_valid", data_valid, 0);
    chk("async_rd_en", mem_rd_en, 0); chk("async_addr", mem_addr, 0);
    chk("async_dout", data_out, 0); chk("async_done", done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", busy, 0);
    fill_mem();
    do_xfer(33, -1, 0, 0);
    check_rx("post_reset");

    // randomized transfers
    for (int k = 0; k < 25; k++) begin
      int l, ab;
      fill_mem();
      l  = $urandom_range(0, DEPTH);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, l + 3) : -1;
      do_xfer(l, ab, (l >= 10) && ($urandom_range(0, 1) == 1), $urandom_range(0, 5) == 0);
      check_rx("random");
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_tx.md
# jtag_tx

Serial configuration bitstream transmitter: reads a configuration image from a word-wide synchronous memory and streams it one bit per clock on `data_out`, qualified by `data_valid`. It is the sending end of the CGRA serial configuration link and drives the `data_in`/`data_valid` inputs of the `jtag2` configuration loader. Bits go out gap-free from the first to the last, so a loader that only counts valid bits receives an exact image.

## Interface
- `WORD_W`, 32: memory word width in bits; must be at least 2.
- `DEPTH`, 4096: maximum image length in bits; must be a multiple of `WORD_W`.
- `LEN_W`, $clog2(DEPTH)+1: width of `len`.
- `ADDR_W`, $clog2(DEPTH/WORD_W): width of the memory address.
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a transfer; honoured only in IDLE.
- `len`  in  LEN_W  number of bits to send, sampled with `start`; legal range 0..DEPTH.
- `abort`  in  1  synchronous cancel of the transfer in progress.
- `mem_rd_en`  out  1  memory read strobe.
- `mem_addr`  out  ADDR_W  memory word address.
- `mem_rd_data`  in  WORD_W  read data, valid exactly one cycle after `mem_rd_en`.
- `data_out`  out  1  serial bit.
- `data_valid`  out  1  `data_out` carries a payload bit.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle `done` pulses.
- `done`  out  1  one-cycle pulse after the last bit of a completed transfer.

## Operation
- States:
  - IDLE: waiting for `start`.
  - FETCH: `mem_rd_en` high with `mem_addr` = 0.
  - LOAD: capture `mem_rd_data` into the shift register.
  - SHIFT: emit bits.
  - DONE: pulse `done`.
- State transitions:
  - IDLE to FETCH on `start` with `len` != 0.
  - IDLE to DONE on `start` with `len` == 0. No reads are issued and `data_valid` never rises.
  - FETCH to LOAD to SHIFT, then SHIFT to DONE after the last bit, then DONE to IDLE.
- Bit order: word 0 first. Within a word, bit 0 goes out first and bit WORD_W-1 last. Image bit i is word i/WORD_W, bit i%WORD_W.
- Word count is ceil(len/WORD_W). Bits of the final word beyond `len` are never emitted.
- Prefetch: in the SHIFT cycle that emits bit 0 of word n, if word n+1 exists, assert `mem_rd_en` with `mem_addr` = n+1. Capture the result into a shadow register on the following cycle. On the last bit of word n, move the shadow into the shift register so that bit 0 of word n+1 appears on the next cycle. There is no gap at any word boundary.
- `abort` in any non-IDLE state returns the block to IDLE on the next edge:
  - `data_valid`, `busy` and `mem_rd_en` drop.
  - No `done` is produced.
  - `abort` has priority over every other transition. In IDLE it has no effect.
- `start` is ignored while `busy`. `start` and `abort` high together in IDLE: `start` wins.
- The bit counter is LEN_W wide and counts 0..len-1. When `len` == DEPTH the counter must not wrap.

## Timing
- Reset values (applied asynchronously while `rst` is low): state IDLE; `data_out`, `data_valid`, `busy`, `done`, `mem_rd_en` = 0; `mem_addr` = 0.
- All outputs are registered.
- Cycle-level sequence, with `start` sampled at edge 0:
  - Cycle 1: FETCH, `mem_rd_en` = 1.
  - Cycle 2: LOAD.
  - Cycle 3: first valid bit.
- First-bit latency is 3 cycles. `data_valid` is high for exactly `len` consecutive cycles, 3..len+2.
- `done` is high in cycle len+3. `busy` is high in cycles 1..len+3.
- For `len` == 0, `done` is high in cycle 1.
- At most one memory read is outstanding. Reads for a transfer use addresses 0..ceil(len/WORD_W)-1, each exactly once.

## Structure
- A shared package `jtag_pkg` holds the state encoding enum and the default `WORD_W`/`DEPTH` constants, shared with `jtag2`.
- Single flat module; shift register, shadow register, bit counter and FSM are small enough that no sub-module is warranted.

## Test plan
- Hold `rst` low, toggle `clk` and `start` -> every output stays 0. Release `rst` -> still idle, nothing happens until a `start`.
- WORD_W=32, mem[0]=0x000000A5, `len`=8, `start` at edge 0 -> `data_out` 1,0,1,0,0,1,0,1 in cycles 3..10 with `data_valid` high; `done` in cycle 11; a single read at address 0.
- `len`=70, mem[0..2] distinct patterns -> reads at addresses 0, 1, 2 only; 70 contiguous valid cycles with no gap at bits 32 and 64; the bits equal the image in order.
- `len`=0 -> `done` in cycle 1, no `mem_rd_en`, no `data_valid`. `start` pulsed while `busy` on a 40-bit transfer -> ignored, exactly 40 valid bits.
- `abort` in the cycle the 10th bit is valid -> `data_valid` low from the next cycle, no `done`. A new `start` with `len`=4 then transmits correctly from address 0.
- Drive `rst` low mid-transfer, between edges -> outputs clear immediately without waiting for a clock edge. After release, the block is idle and a fresh transfer completes.
